// File: rtl/replay_queue.sv
// Circular replay queue: write, read and checkpoint pointers. Entries that have been
// popped stay resident between the checkpoint and the read pointer until commit releases them.
module replay_queue #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int LOW_MARK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              commit,
  input  logic              rewind,
  output logic              full,
  output logic              low_water,
  output logic [ADDR_W:0]   avail,
  output logic [ADDR_W:0]   used,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LOW_CNT  = (ADDR_W+1)'(LOW_MARK);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr, ck_ptr;
  logic              push_ok, pop_ok, pop_bad;

  // Extra wrap bit makes the subtraction exact for a completely full buffer.
  assign avail     = wr_ptr - rd_ptr;
  assign used      = wr_ptr - ck_ptr;
  assign valid     = (avail != '0);
  assign full      = (used == FULL_CNT);
  assign low_water = (avail < LOW_CNT);
  assign data_out  = mem[rd_ptr[ADDR_W-1:0]];

  assign push_ok = push && !full;
  assign pop_ok  = pop && valid && !rewind;
  assign pop_bad = pop && !valid && !rewind;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ck_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      // Rewind wins over both pop and commit; commit captures the pre-pop read pointer.
      if (rewind)      rd_ptr <= ck_ptr;
      else if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (commit && !rewind) ck_ptr <= rd_ptr;
      if (push && full) overflow  <= 1'b1;
      if (pop_bad)      underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_replay_queue.sv
// Directed bench for replay_queue at DEPTH=8, LOW_MARK=4 with hand-computed expectations.
module tb_replay_queue;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst, push, pop, commit, rewind;
  logic [DW-1:0] data_in, data_out;
  logic          valid, full, low_water, overflow, underflow;
  logic [AW:0]   avail, used;

  int n_tests = 0;
  int n_fail  = 0;

  replay_queue #(.DATA_W(DW), .DEPTH(8), .ADDR_W(AW), .LOW_MARK(4)) dut (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid(valid), .commit(commit), .rewind(rewind),
    .full(full), .low_water(low_water), .avail(avail), .used(used),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs; returns #1 after the edge so outputs show the new state.
  task automatic cyc(input logic r, input logic p, input logic [DW-1:0] d,
                     input logic po, input logic c, input logic rw);
    rst = r; push = p; data_in = d; pop = po; commit = c; rewind = rw;
    @(posedge clk); #1;
    rst = 0; push = 0; pop = 0; commit = 0; rewind = 0;
  endtask

  initial begin
    rst = 0; push = 0; pop = 0; commit = 0; rewind = 0; data_in = '0;
    #2;

    // reset state
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_low",   32'(low_water), 1);
    chk("rst_avail", 32'(avail), 0);
    chk("rst_used",  32'(used), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_udf",   32'(underflow), 0);

    // basic push and low watermark
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'hA0 + i), 0, 0, 0);
    chk("p3_avail", 32'(avail), 3);
    chk("p3_used",  32'(used), 3);
    chk("p3_low",   32'(low_water), 1);
    chk("p3_dout",  32'(data_out), 32'hA0);
    chk("p3_valid", 32'(valid), 1);
    cyc(0, 1, 8'hA3, 0, 0, 0);
    chk("p4_low",   32'(low_water), 0);
    chk("p4_avail", 32'(avail), 4);

    // fill, overflow, pop with retention, commit frees space
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h10 + i), 0, 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_used", 32'(used), 8);
    cyc(0, 1, 8'hFF, 0, 0, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_used", 32'(used), 8);
    chk("ovf_dout", 32'(data_out), 32'h10);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("pop3_full",  32'(full), 1);
    chk("pop3_avail", 32'(avail), 5);
    chk("pop3_dout",  32'(data_out), 32'h13);
    cyc(0, 0, 0, 0, 1, 0);
    chk("cmt_used", 32'(used), 5);
    chk("cmt_full", 32'(full), 0);
    chk("cmt_dout", 32'(data_out), 32'h13);

    // pop sequence then rewind replays from the checkpoint
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'(8'h20 + i), 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_dout%0d", i), 32'(data_out), 32'(8'h20 + i));
      cyc(0, 0, 0, 1, 0, 0);
    end
    chk("seq_avail", 32'(avail), 2);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rw_dout",  32'(data_out), 32'h20);
    chk("rw_avail", 32'(avail), 6);
    chk("rw_used",  32'(used), 6);

    // pop+rewind: rewind wins, no underflow
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("pre_prw_dout", 32'(data_out), 32'h22);
    cyc(0, 0, 0, 1, 0, 1);
    chk("prw_dout",  32'(data_out), 32'h20);
    chk("prw_avail", 32'(avail), 6);
    chk("prw_udf",   32'(underflow), 0);

    // pop+commit: checkpoint takes the pre-pop read pointer (3), read moves to 4
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("pc_used",  32'(used), 3);
    chk("pc_avail", 32'(avail), 2);
    chk("pc_dout",  32'(data_out), 32'h24);

    // index wrap with two resident entries
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 8'h30, 0, 0, 0);
    cyc(0, 1, 8'h31, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 8'(8'h32 + i), 1, 1, 0);
      chk($sformatf("wrap_dout%0d", i),  32'(data_out), 32'(8'h31 + i));
      chk($sformatf("wrap_avail%0d", i), 32'(avail), 2);
      chk($sformatf("wrap_used%0d", i),  32'(used), 3);
    end

    // empty pop, then push+pop on empty (no bypass)
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("epop_udf",   32'(underflow), 1);
    chk("epop_avail", 32'(avail), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst2_udf", 32'(underflow), 0);
    cyc(0, 1, 8'h40, 1, 0, 0);
    chk("pp_udf",   32'(underflow), 1);
    chk("pp_avail", 32'(avail), 1);
    chk("pp_dout",  32'(data_out), 32'h40);

    // build used=5 with both sticky flags set, then reset mid-operation
    for (int i = 0; i < 7; i++) cyc(0, 1, 8'(8'h41 + i), 0, 0, 0);
    cyc(0, 1, 8'hEE, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("mid_used", 32'(used), 5);
    chk("mid_ovf",  32'(overflow), 1);
    chk("mid_udf",  32'(underflow), 1);
    cyc(1, 1, 8'h55, 1, 1, 0);
    chk("mrst_avail", 32'(avail), 0);
    chk("mrst_used",  32'(used), 0);
    chk("mrst_ovf",   32'(overflow), 0);
    chk("mrst_udf",   32'(underflow), 0);
    chk("mrst_valid", 32'(valid), 0);
    chk("mrst_full",  32'(full), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/replay_queue.md
Name: replay_queue

Overview:
- Parametrised successor to the single-width storage queue: circular buffer with a write pointer, a read pointer and a checkpoint pointer.
- Entries between the checkpoint and the read pointer are retained after being popped, so the consumer can rewind and replay them.
- Adds exact full/empty accounting, a programmable low-watermark, overflow/underflow sticky flags, and occupancy outputs.
- Sits between the operand producer and the execution consumer, which may need to re-issue a speculatively consumed operand sequence.

Parameters:
- DATA_W, 32, width of one stored entry.
- DEPTH, 64, number of entries; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH), index width; pointers are ADDR_W+1 bits (extra wrap bit).
- LOW_MARK, 4, low_water asserts while readable entries < LOW_MARK; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- push  in  1  write data_in at wr_ptr.
- data_in  in  DATA_W  write data.
- pop  in  1  advance rd_ptr by one.
- data_out  out  DATA_W  mem[rd_ptr], combinational read; value undefined when valid=0.
- valid  out  1  readable count > 0.
- commit  in  1  ck_ptr <= rd_ptr, releasing replay entries.
- rewind  in  1  rd_ptr <= ck_ptr, replaying from the checkpoint.
- full  out  1  retained count == DEPTH.
- low_water  out  1  readable count < LOW_MARK.
- avail  out  ADDR_W+1  readable count = wr_ptr - rd_ptr.
- used  out  ADDR_W+1  retained count = wr_ptr - ck_ptr.
- overflow  out  1  sticky; set when a push is dropped.
- underflow  out  1  sticky; set when a pop is ignored.

Behaviour:
- Reset (rst=1 at clk edge): wr_ptr, rd_ptr and ck_ptr all go to 0; overflow and underflow clear.
  - After reset: valid=0, full=0, low_water=1, avail=0, used=0.
  - Memory contents are not reset.
  - rst dominates every other input in the same cycle.
- Pointer arithmetic is modulo 2^(ADDR_W+1); the memory index is ptr[ADDR_W-1:0]. Wrap-around is seamless.
- All outputs except data_out are combinational from registered state only. No input-to-output combinational paths other than the data_out read address.
- Push:
  - Accepted iff push && !full; mem[wr_ptr] <= data_in and wr_ptr += 1.
  - push && full: write dropped, pointers unchanged, overflow <= 1.
- Pop:
  - Accepted iff pop && valid && !rewind; rd_ptr += 1.
  - pop && !valid && !rewind: ignored, underflow <= 1.
  - No write-to-read bypass: a push and a pop in the same cycle with avail=0 rejects the pop and sets underflow. Pushed data is readable the cycle after the push.
- Commit:
  - ck_ptr <= rd_ptr value at the start of the cycle, i.e. before any same-cycle pop.
  - commit with rd_ptr == ck_ptr is a no-op.
- Rewind:
  - rd_ptr <= ck_ptr.
  - Has priority over pop: the pop is dropped with no underflow.
  - Has priority over commit: the commit is dropped.
- Simultaneous events:
  - push is independent of pop, commit and rewind.
  - full is evaluated from registered state. A push in the same cycle as a commit that frees space is still dropped if full=1.
- Invariant: ck_ptr <= rd_ptr <= wr_ptr in modular distance, so avail <= used <= DEPTH. Violations are a design bug.
- Latency: push to valid is 1 cycle. Pop, commit and rewind take effect on data_out and the counts 1 cycle after the edge.

Test Plan:
- DEPTH=8, LOW_MARK=4. Reset, push 0xA0..0xA2 on consecutive cycles -> avail=3, used=3, low_water=1, data_out=0xA0. Fourth push 0xA3 -> low_water=0.
- Push 8 entries 0x10..0x17, then push 0xFF -> full=1, 0xFF dropped, overflow=1, used=8. Pop 3 -> full stays 1. Commit -> used=5, full=0.
- Push 0x20..0x25, pop 4 (data_out sequence 0x20,0x21,0x22,0x23), rewind -> next cycle data_out=0x20, avail=6, used=6.
- Same cycle pop+rewind with rd_ptr=ck_ptr+2 -> rd_ptr=ck_ptr, no underflow. Same cycle pop+commit with rd_ptr=3 -> ck_ptr=3, rd_ptr=4.
- Pointer wrap: 20 push/pop/commit rounds on DEPTH=8 with 2 entries resident -> data order preserved across the index wrap, avail=2 throughout.
- Empty pop, and push+pop on an empty queue -> pop rejected, underflow=1, avail=1 after. Mid-operation rst with used=5 -> next cycle all counts 0 and both sticky flags cleared.
